inst_fetch_queue: RTL and testbench

//  Sits directly downstream of the program-counter stage. Fetches instructions from

---
 rtl/inst_fetch_queue_pkg.sv | 19 +
 rtl/inst_fetch_queue_sync_fifo.sv | 69 ++++++
 rtl/inst_fetch_queue.sv | 127 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_DATA_WIDTH = 32;
  localparam int INST_BYTES      = 4;

  // One queued instruction: the fetched word and the PC it was fetched from.
  typedef struct packed {
    logic [INST_DATA_WIDTH-1:0] data;
    logic [INST_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  // Force a PC onto an instruction boundary by clearing its two low bits.
  function automatic logic [INST_ADDR_WIDTH-1:0] align_pc(input logic [INST_ADDR_WIDTH-1:0] pc);
    return {pc[INST_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Registered synchronous FIFO with flush; head data reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == CW'(0));
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Occupancy change for this cycle's push/pop combination.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and storage update; flush empties without touching storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: sequential fetch with credit control, redirect flush
// and stale-response dropping, feeding decode over valid/ready.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                         DEPTH    = 4,
  parameter int                         MAX_OUT  = 2,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_i,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                       mem_req_o,
  output logic [INST_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic [INST_DATA_WIDTH-1:0] mem_rdata_i,
  output logic                       inst_valid_o,
  output logic [INST_DATA_WIDTH-1:0] inst_o,
  output logic [INST_ADDR_WIDTH-1:0] inst_pc_o,
  input  logic                       inst_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;

  logic [INST_ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [INST_ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]              inflight_q, inflight_d;
  logic [OW-1:0]              drop_q, drop_d;
  logic [CW-1:0]              fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic                       grant;
  logic                       resp_ok;
  fetch_entry_t               push_entry;
  fetch_entry_t               head_entry;

  // Issue only while both a request slot and a guaranteed queue slot exist;
  // responses already marked for dropping do not consume queue space.
  assign mem_req_o = !reset && !redirect_i
                     && (int'(inflight_q) < MAX_OUT)
                     && ((int'(fifo_count) + int'(inflight_q) - int'(drop_q)) < DEPTH);
  assign mem_addr_o = fetch_addr_q;
  assign grant      = mem_req_o && mem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok    = mem_rvalid_i && (inflight_q != OW'(0));
  assign pop        = inst_valid_o && inst_ready_i;
  assign push_entry = '{data: mem_rdata_i, pc: resp_pc_q};

  assign inst_valid_o = !fifo_empty;
  assign inst_o       = head_entry.data;
  assign inst_pc_o    = head_entry.pc;

  // Next-state for fetch/response PCs and the outstanding/drop counters.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    resp_pc_d    = resp_pc_q;
    inflight_d   = inflight_q;
    drop_d       = drop_q;
    push         = 1'b0;
    if (grant) begin
      fetch_addr_d = fetch_addr_q + INST_ADDR_WIDTH'(INST_BYTES);
      inflight_d   = inflight_q + OW'(1);
    end else begin
      fetch_addr_d = fetch_addr_q;
    end
    if (resp_ok) begin
      inflight_d = inflight_d - OW'(1);
      if (drop_q != OW'(0)) begin
        drop_d = drop_q - OW'(1);
      end else begin
        push      = 1'b1;
        resp_pc_d = resp_pc_q + INST_ADDR_WIDTH'(INST_BYTES);
      end
    end else begin
      drop_d = drop_q;
    end
    // Every response still owed after a redirect belongs to the old path.
    if (redirect_i) begin
      fetch_addr_d = align_pc(redirect_pc_i);
      resp_pc_d    = align_pc(redirect_pc_i);
      drop_d       = inflight_d;
      push         = 1'b0;
    end else begin
      resp_pc_d = resp_pc_d;
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr_q <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      inflight_q   <= '0;
      drop_q       <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      resp_pc_q    <= resp_pc_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;

  inst_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding requests by address (stale after a redirect),
  // and the decode queue as {pc, data} pairs.
  typedef struct { logic [31:0] addr; bit stale; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  out_t        out_q[$];
  ent_t        dq[$];
  logic [31:0] m_fetch;
  bit          prev_rst;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit rst, input bit redir, input logic [31:0] tgt,
                      input bit gnt, input bit rv, input bit ready, input bit chk_en);
    int   live;
    bit   exp_req;
    bit   grant;
    bit   have_resp;
    out_t resp;
    @(negedge clk);
    reset         = rst;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    mem_gnt_i     = gnt;
    inst_ready_i  = ready;
    mem_rvalid_i  = rv;
    mem_rdata_i   = (out_q.size() > 0) ? mem_word(out_q[0].addr) : $urandom;
    #1;
    live = 0;
    foreach (out_q[i]) if (!out_q[i].stale) live++;
    exp_req = !rst && !redir && (out_q.size() < MAX_OUT) && ((dq.size() + live) < DEPTH);
    if (chk_en) begin
      check("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
      check("mem_addr", mem_addr_o, m_fetch);
      check("inst_valid", {31'b0, inst_valid_o}, {31'b0, dq.size() != 0});
      if (dq.size() != 0) begin
        check("inst_pc", inst_pc_o, dq[0].pc);
        check("inst_data", inst_o, dq[0].data);
      end
      if (prev_rst) begin
        check("rst_inst", inst_o, 32'h0);
        check("rst_pc", inst_pc_o, 32'h0);
      end
    end
    // Model update for the coming edge.
    if (rst) begin
      out_q.delete();
      dq.delete();
      m_fetch = RESET_PC;
    end else begin
      grant     = exp_req && gnt;
      have_resp = rv && (out_q.size() > 0);
      if (have_resp) resp = out_q.pop_front();
      if (redir) begin
        dq.delete();
        foreach (out_q[i]) out_q[i].stale = 1'b1;
        m_fetch = tgt & 32'hFFFF_FFFC;
      end else begin
        if (dq.size() != 0 && ready) void'(dq.pop_front());
        if (have_resp && !resp.stale) dq.push_back('{pc: resp.addr, data: mem_word(resp.addr)});
        if (grant) begin
          out_q.push_back('{addr: m_fetch, stale: 1'b0});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    prev_rst = rst;
  endtask

  task automatic run(input int n, input int p_gnt, input int p_rv, input int p_rdy,
                     input int p_redir, input int p_rst);
    logic [31:0] tgts [4];
    logic [31:0] t;
    tgts = '{32'h0000_0103, 32'hFFFF_FFFC, 32'h0000_0040, 32'h7FFF_FFF2};
    for (int i = 0; i < n; i++) begin
      t = ($urandom_range(0, 1) == 0) ? tgts[$urandom_range(0, 3)] : $urandom;
      step($urandom_range(0, 99) < p_rst, $urandom_range(0, 99) < p_redir, t,
           $urandom_range(0, 99) < p_gnt, $urandom_range(0, 99) < p_rv,
           $urandom_range(0, 99) < p_rdy, 1'b1);
    end
  endtask

  initial begin
    m_fetch  = RESET_PC;
    prev_rst = 1'b0;
    // Reset; the first cycle's outputs are still unknown.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Streaming: always granted, 1-cycle responses, decode always ready.
    run(20, 100, 100, 100, 0, 0);
    // Decode stalls: the queue fills and requests stop, then resume.
    run(12, 100, 100, 0, 0, 0);
    run(10, 100, 100, 100, 0, 0);
    // Two requests outstanding, then redirect to an unaligned target.
    run(2, 100, 0, 0, 0, 0);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0, 1'b1, 1'b1);
    run(12, 100, 100, 100, 0, 0);
    // Redirect coinciding with a response and a pop.
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b1, 1'b1);
    run(10, 100, 100, 100, 0, 0);
    // Redirect near the top of the address space: fetch wraps to zero.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b1);
    run(8, 100, 100, 100, 0, 0);
    // Build up queued and in-flight work, then reset mid-stream.
    run(4, 100, 100, 0, 0, 0);
    run(2, 100, 0, 0, 0, 0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    run(10, 100, 100, 100, 0, 0);
    // Random traffic including spurious responses, redirects and resets.
    run(3000, 60, 50, 60, 3, 1);
    run(500, 90, 90, 30, 8, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
